mouse_pos_tracker: RTL

MOUSE_POS_TRACKER -- requirements
Module: mouse_pos_tracker

---
 rtl/mouse_pos_tracker.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mouse_pos_tracker.sv
// rtl/mouse_pos_tracker.sv - PS/2 mouse packet decoder with clamped cursor position tracking
module mouse_pos_tracker #(
    parameter int X_MAX   = 799,
    parameter int Y_MAX   = 599,
    parameter int X_INIT  = 400,
    parameter int Y_INIT  = 300,
    parameter int TIMEOUT = 255
) (
    input  logic        clk_div,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [11:0] mouse_xpos,
    output logic [11:0] mouse_ypos,
    output logic        mouse_left,
    output logic        packet_done
);

    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, UPDATE} state_t;

    localparam logic signed [13:0] X_MAX_S   = 14'(X_MAX);
    localparam logic signed [13:0] Y_MAX_S   = 14'(Y_MAX);
    localparam logic [11:0]        X_INIT_V  = 12'(X_INIT);
    localparam logic [11:0]        Y_INIT_V  = 12'(Y_INIT);
    localparam logic [15:0]        TIMEOUT_V = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic [15:0] idle_q, idle_d;
    // Status fields kept: {y_ovf, x_ovf, y_sign, x_sign, left}
    logic [4:0]  status_q, status_d;
    logic [7:0]  dx_byte_q, dx_byte_d;
    logic [7:0]  dy_byte_q, dy_byte_d;
    logic [11:0] xpos_q, xpos_d;
    logic [11:0] ypos_q, ypos_d;
    logic        left_q, left_d;
    logic        done_q, done_d;

    logic signed [8:0]  dx_s, dy_s;
    logic signed [13:0] new_x, new_y;

    // State register; reset aborts any packet in flight
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) state_q <= WAIT_B0;
        else     state_q <= state_d;
    end

    // Input capture stage plus packet/idle bookkeeping and cursor outputs
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            idle_q     <= 16'd0;
            status_q   <= 5'd0;
            dx_byte_q  <= 8'd0;
            dy_byte_q  <= 8'd0;
            xpos_q     <= X_INIT_V;
            ypos_q     <= Y_INIT_V;
            left_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rx_data_q  <= rx_data;
            rx_valid_q <= rx_valid;
            idle_q     <= idle_d;
            status_q   <= status_d;
            dx_byte_q  <= dx_byte_d;
            dy_byte_q  <= dy_byte_d;
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            left_q     <= left_d;
            done_q     <= done_d;
        end
    end

    // Next state: byte sequencing, resync on bad status byte, idle timeout
    always_comb begin
        state_d   = state_q;
        idle_d    = idle_q;
        status_d  = status_q;
        dx_byte_d = dx_byte_q;
        dy_byte_d = dy_byte_q;
        case (state_q)
            WAIT_B0: begin
                idle_d = 16'd0;
                if (rx_valid_q && rx_data_q[3]) begin
                    status_d = {rx_data_q[7:4], rx_data_q[0]};
                    state_d  = WAIT_B1;
                end
            end
            WAIT_B1: begin
                if (rx_valid_q) begin
                    dx_byte_d = rx_data_q;
                    idle_d    = 16'd0;
                    state_d   = WAIT_B2;
                end else if (idle_q == TIMEOUT_V) begin
                    idle_d  = 16'd0;
                    state_d = WAIT_B0;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
            WAIT_B2: begin
                if (rx_valid_q) begin
                    dy_byte_d = rx_data_q;
                    idle_d    = 16'd0;
                    state_d   = UPDATE;
                end else if (idle_q == TIMEOUT_V) begin
                    idle_d  = 16'd0;
                    state_d = WAIT_B0;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
            UPDATE: begin
                // Any byte presented now is dropped
                idle_d  = 16'd0;
                state_d = WAIT_B0;
            end
            default: state_d = WAIT_B0;
        endcase
    end

    // Outputs: apply signed deltas with clamping, load only when leaving UPDATE
    always_comb begin
        dx_s   = status_q[3] ? 9'sd0 : $signed({status_q[1], dx_byte_q});
        dy_s   = status_q[4] ? 9'sd0 : $signed({status_q[2], dy_byte_q});
        new_x  = $signed({2'b00, xpos_q}) + {{5{dx_s[8]}}, dx_s};
        new_y  = $signed({2'b00, ypos_q}) - {{5{dy_s[8]}}, dy_s};
        xpos_d = xpos_q;
        ypos_d = ypos_q;
        left_d = left_q;
        done_d = 1'b0;
        if (state_q == UPDATE) begin
            if (new_x < 14'sd0)        xpos_d = 12'd0;
            else if (new_x > X_MAX_S)  xpos_d = X_MAX_S[11:0];
            else                       xpos_d = new_x[11:0];
            if (new_y < 14'sd0)        ypos_d = 12'd0;
            else if (new_y > Y_MAX_S)  ypos_d = Y_MAX_S[11:0];
            else                       ypos_d = new_y[11:0];
            left_d = status_q[0];
            done_d = 1'b1;
        end
    end

    assign mouse_xpos  = xpos_q;
    assign mouse_ypos  = ypos_q;
    assign mouse_left  = left_q;
    assign packet_done = done_q;

endmodule
